// File: rtl/aes_key_expansion.sv
// Iterative AES-128 key schedule: one round key per clock, eleven round keys
// held in a register file and read combinationally by round index.
// Optional build macro AES_KEY_ZEROIZE_EN adds the i_Zeroize port, which
// clears all key material and aborts any expansion in progress.
module aes_key_expansion #(
    parameter int unsigned NR = 10
) (
    input  logic         clk,
    input  logic         rst,
`ifdef AES_KEY_ZEROIZE_EN
    input  logic         i_Zeroize,
`endif
    input  logic         i_Start,
    input  logic [127:0] i_Key,
    input  logic [3:0]   i_Round_Sel,
    output logic [127:0] o_Round_Key,
    output logic         o_Busy,
    output logic         o_Done,
    output logic         o_Keys_Valid
);

    if (NR != 10) begin : g_nr_check
        $error("aes_key_expansion: NR must be 10 (AES-128 only)");
    end

    // Forward S-box, entry 0 first.
    localparam logic [0:255][7:0] SBOX = {
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // Multiply by x in GF(2^8) modulo the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    typedef enum logic [0:0] {StIdle, StExpand} state_e;

    state_e       state_q;
    logic [127:0] rk_q [0:NR];
    logic [7:0]   rcon_q;
    logic [3:0]   cnt_q;
    logic         busy_q;
    logic         done_q;
    logic         valid_q;

    logic [3:0]   prev_idx;
    logic [127:0] prev_rk;
    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rot_word, sub_word, temp;
    logic [31:0]  n0, n1, n2, n3;
    logic [127:0] next_rk;
    logic         zeroize;

`ifdef AES_KEY_ZEROIZE_EN
    assign zeroize = i_Zeroize;
`else
    assign zeroize = 1'b0;
`endif

    // Next round key derived from the previously written one.
    always_comb begin
        prev_idx = cnt_q - 4'd1;
        prev_rk  = rk_q[prev_idx];
        w0       = prev_rk[127:96];
        w1       = prev_rk[95:64];
        w2       = prev_rk[63:32];
        w3       = prev_rk[31:0];
        rot_word = {w3[23:0], w3[31:24]};
        sub_word = {sbox(rot_word[31:24]), sbox(rot_word[23:16]),
                    sbox(rot_word[15:8]),  sbox(rot_word[7:0])};
        temp     = sub_word ^ {rcon_q, 24'h0};
        n0       = w0 ^ temp;
        n1       = w1 ^ n0;
        n2       = w2 ^ n1;
        n3       = w3 ^ n2;
        next_rk  = {n0, n1, n2, n3};
    end

    // Sequencer, key storage and registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            rk_q    <= '{default: '0};
            rcon_q  <= 8'h01;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (zeroize) begin
            state_q <= StIdle;
            rk_q    <= '{default: '0};
            rcon_q  <= 8'h01;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (i_Start) begin
                        rk_q[0] <= i_Key;
                        cnt_q   <= 4'd1;
                        rcon_q  <= 8'h01;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= StExpand;
                    end
                end
                StExpand: begin
                    rk_q[cnt_q] <= next_rk;
                    rcon_q      <= xtime(rcon_q);
                    cnt_q       <= cnt_q + 4'd1;
                    if (cnt_q == 4'(NR)) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        valid_q <= 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Combinational read port; indices past the last round read as zero.
    always_comb begin
        o_Round_Key = '0;
        if (i_Round_Sel <= 4'(NR)) begin
            o_Round_Key = rk_q[i_Round_Sel];
        end
    end

    assign o_Busy       = busy_q;
    assign o_Done       = done_q;
    assign o_Keys_Valid = valid_q;

endmodule

// File: tb/tb_aes_key_expansion.sv
// Self-checking bench for aes_key_expansion. The reference model runs the
// word-oriented key schedule with an S-box derived from GF(2^8) inversion.
`timescale 1ns/1ps
module tb_aes_key_expansion;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         i_Start = 1'b0;
    logic [127:0] i_Key = '0;
    logic [3:0]   i_Round_Sel = '0;
    logic [127:0] o_Round_Key;
    logic         o_Busy;
    logic         o_Done;
    logic         o_Keys_Valid;
`ifdef AES_KEY_ZEROIZE_EN
    logic         i_Zeroize = 1'b0;
`endif

    int vectors = 0;
    int miscompares = 0;
    logic [127:0] exp_rk [0:10];

    always #50 clk = ~clk;

    aes_key_expansion #(.NR(10)) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef AES_KEY_ZEROIZE_EN
        .i_Zeroize    (i_Zeroize),
`endif
        .i_Start      (i_Start),
        .i_Key        (i_Key),
        .i_Round_Sel  (i_Round_Sel),
        .o_Round_Key  (o_Round_Key),
        .o_Busy       (o_Busy),
        .o_Done       (o_Done),
        .o_Keys_Valid (o_Keys_Valid)
    );

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = '0;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    // Multiplicative inverse (x^254) followed by the affine transform.
    function automatic logic [7:0] sbox_ref(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gmul(inv, x);
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_ref(t[31:24]), sbox_ref(t[23:16]), sbox_ref(t[15:8]),
                     sbox_ref(t[7:0])} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Accept a start, then count edges until o_Done (-1 if it never comes).
    task automatic run_expansion(input logic [127:0] key, output int done_cycle);
        i_Key = key;
        i_Start = 1'b1;
        tick();
        i_Start = 1'b0;
        i_Key = rand_key();
        done_cycle = -1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (o_Done === 1'b1) begin
                done_cycle = k;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if ({o_Busy, o_Done, o_Keys_Valid} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_status: got %b, expected 000", {o_Busy, o_Done, o_Keys_Valid});
        end
        for (int s = 0; s < 16; s++) begin
            i_Round_Sel = 4'(s);
            #1;
            vectors++;
            if (o_Round_Key !== 128'h0) begin
                miscompares++;
                $display("FAIL reset_rk[%0d]: got %h, expected 0", s, o_Round_Key);
            end
        end
        #10;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_fips();
        int dc;
        logic [127:0] key;
        key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        model_expand(key);
        run_expansion(key, dc);
        vectors++;
        if (dc !== 10) begin
            miscompares++;
            $display("FAIL fips_done_latency: got %0d, expected 10", dc);
        end
        vectors++;
        if ({o_Busy, o_Keys_Valid} !== 2'b01) begin
            miscompares++;
            $display("FAIL fips_status: got busy,valid=%b, expected 01", {o_Busy, o_Keys_Valid});
        end
        i_Round_Sel = 4'd0;
        #1;
        vectors++;
        if (o_Round_Key !== key) begin
            miscompares++;
            $display("FAIL fips_rk0: got %h, expected %h", o_Round_Key, key);
        end
        i_Round_Sel = 4'd1;
        #1;
        vectors++;
        if (o_Round_Key !== 128'ha0fafe1788542cb123a339392a6c7605) begin
            miscompares++;
            $display("FAIL fips_rk1: got %h, expected a0fafe1788542cb123a339392a6c7605", o_Round_Key);
        end
        i_Round_Sel = 4'd10;
        #1;
        vectors++;
        if (o_Round_Key !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
            miscompares++;
            $display("FAIL fips_rk10: got %h, expected d014f9a8c9ee2589e13f0cc8b6630ca6", o_Round_Key);
        end
        for (int s = 0; s <= 10; s++) begin
            i_Round_Sel = 4'(s);
            #1;
            vectors++;
            if (o_Round_Key !== exp_rk[s]) begin
                miscompares++;
                $display("FAIL fips_model_rk[%0d]: got %h, expected %h", s, o_Round_Key, exp_rk[s]);
            end
        end
        tick();
        vectors++;
        if ({o_Done, o_Keys_Valid} !== 2'b01) begin
            miscompares++;
            $display("FAIL fips_done_pulse: got done,valid=%b, expected 01", {o_Done, o_Keys_Valid});
        end
    endtask

    task automatic test_back_to_back();
        int dc;
        run_expansion(rand_key(), dc);
        vectors++;
        if (dc !== 10) begin
            miscompares++;
            $display("FAIL b2b_first_done: got %0d, expected 10", dc);
        end
        // Currently in the o_Done cycle: a start here must be accepted.
        i_Key = 128'h0;
        i_Start = 1'b1;
        tick();
        i_Start = 1'b0;
        i_Key = rand_key();
        vectors++;
        if ({o_Busy, o_Done, o_Keys_Valid} !== 3'b100) begin
            miscompares++;
            $display("FAIL b2b_restart_status: got %b, expected 100", {o_Busy, o_Done, o_Keys_Valid});
        end
        dc = -1;
        for (int k = 1; k <= 14; k++) begin
            tick();
            if (o_Done === 1'b1) begin
                dc = k;
                break;
            end
        end
        vectors++;
        if (dc !== 10) begin
            miscompares++;
            $display("FAIL b2b_second_done: got %0d, expected 10", dc);
        end
        i_Round_Sel = 4'd1;
        #1;
        vectors++;
        if (o_Round_Key !== 128'h62636363626363636263636362636363) begin
            miscompares++;
            $display("FAIL zero_rk1: got %h, expected 62636363626363636263636362636363", o_Round_Key);
        end
        i_Round_Sel = 4'd10;
        #1;
        vectors++;
        if (o_Round_Key !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin
            miscompares++;
            $display("FAIL zero_rk10: got %h, expected b4ef5bcb3e92e21123e951cf6f8f188e", o_Round_Key);
        end
        model_expand(128'h0);
        for (int s = 0; s <= 10; s++) begin
            i_Round_Sel = 4'(s);
            #1;
            vectors++;
            if (o_Round_Key !== exp_rk[s]) begin
                miscompares++;
                $display("FAIL zero_model_rk[%0d]: got %h, expected %h", s, o_Round_Key, exp_rk[s]);
            end
        end
    endtask

    task automatic test_ignore_start();
        int dc;
        logic [127:0] key_a;
        key_a = rand_key();
        model_expand(key_a);
        i_Key = key_a;
        i_Start = 1'b1;
        tick();
        dc = -1;
        for (int k = 1; k <= 14; k++) begin
            i_Start = (k == 4);
            i_Key = rand_key();
            tick();
            if (o_Done === 1'b1) begin
                dc = k;
                break;
            end
        end
        i_Start = 1'b0;
        vectors++;
        if (dc !== 10) begin
            miscompares++;
            $display("FAIL ignore_done_latency: got %0d, expected 10", dc);
        end
        for (int s = 0; s <= 10; s++) begin
            i_Round_Sel = 4'(s);
            #1;
            vectors++;
            if (o_Round_Key !== exp_rk[s]) begin
                miscompares++;
                $display("FAIL ignore_rk[%0d]: got %h, expected %h", s, o_Round_Key, exp_rk[s]);
            end
        end
        tick();
    endtask

    task automatic test_random();
        int dc;
        logic [127:0] key;
        for (int n = 0; n < 5; n++) begin
            key = rand_key();
            model_expand(key);
            run_expansion(key, dc);
            vectors++;
            if (dc !== 10) begin
                miscompares++;
                $display("FAIL rand%0d_done_latency: got %0d, expected 10", n, dc);
            end
            for (int s = 0; s <= 10; s++) begin
                i_Round_Sel = 4'(s);
                #1;
                vectors++;
                if (o_Round_Key !== exp_rk[s]) begin
                    miscompares++;
                    $display("FAIL rand%0d_rk[%0d]: got %h, expected %h", n, s, o_Round_Key, exp_rk[s]);
                end
            end
            repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    task automatic test_out_of_range();
        for (int s = 11; s < 16; s++) begin
            i_Round_Sel = 4'(s);
            #1;
            vectors++;
            if (o_Round_Key !== 128'h0) begin
                miscompares++;
                $display("FAIL oor_rk[%0d]: got %h, expected 0", s, o_Round_Key);
            end
        end
        vectors++;
        if (o_Keys_Valid !== 1'b1) begin
            miscompares++;
            $display("FAIL oor_valid: got %b, expected 1", o_Keys_Valid);
        end
    endtask

    task automatic test_async_reset();
        bit seen_done;
        i_Key = rand_key();
        i_Start = 1'b1;
        tick();
        i_Start = 1'b0;
        repeat (4) tick();
        #10;
        rst = 1'b1;
        #1;
        vectors++;
        if ({o_Busy, o_Done, o_Keys_Valid} !== 3'b000) begin
            miscompares++;
            $display("FAIL areset_status: got %b, expected 000", {o_Busy, o_Done, o_Keys_Valid});
        end
        for (int s = 0; s <= 10; s++) begin
            i_Round_Sel = 4'(s);
            #1;
            vectors++;
            if (o_Round_Key !== 128'h0) begin
                miscompares++;
                $display("FAIL areset_rk[%0d]: got %h, expected 0", s, o_Round_Key);
            end
        end
        #5;
        rst = 1'b0;
        seen_done = 1'b0;
        for (int k = 0; k < 14; k++) begin
            tick();
            if (o_Done === 1'b1) seen_done = 1'b1;
        end
        vectors++;
        if ({seen_done, o_Busy, o_Keys_Valid} !== 3'b000) begin
            miscompares++;
            $display("FAIL areset_after: got done_seen,busy,valid=%b, expected 000",
                     {seen_done, o_Busy, o_Keys_Valid});
        end
    endtask

`ifdef AES_KEY_ZEROIZE_EN
    task automatic test_zeroize();
        int dc;
        bit seen_done;
        run_expansion(rand_key(), dc);
        vectors++;
        if (dc !== 10) begin
            miscompares++;
            $display("FAIL zeroize_pre_done: got %0d, expected 10", dc);
        end
        i_Zeroize = 1'b1;
        i_Start = 1'b1;
        i_Key = rand_key();
        tick();
        i_Zeroize = 1'b0;
        i_Start = 1'b0;
        tick();
        vectors++;
        if ({o_Busy, o_Done, o_Keys_Valid} !== 3'b000) begin
            miscompares++;
            $display("FAIL zeroize_start_status: got %b, expected 000", {o_Busy, o_Done, o_Keys_Valid});
        end
        for (int s = 0; s < 16; s++) begin
            i_Round_Sel = 4'(s);
            #1;
            vectors++;
            if (o_Round_Key !== 128'h0) begin
                miscompares++;
                $display("FAIL zeroize_rk[%0d]: got %h, expected 0", s, o_Round_Key);
            end
        end
        i_Key = rand_key();
        i_Start = 1'b1;
        tick();
        i_Start = 1'b0;
        repeat (2) tick();
        i_Zeroize = 1'b1;
        tick();
        i_Zeroize = 1'b0;
        vectors++;
        if ({o_Busy, o_Keys_Valid} !== 2'b00) begin
            miscompares++;
            $display("FAIL zeroize_abort_status: got %b, expected 00", {o_Busy, o_Keys_Valid});
        end
        for (int s = 0; s <= 10; s++) begin
            i_Round_Sel = 4'(s);
            #1;
            vectors++;
            if (o_Round_Key !== 128'h0) begin
                miscompares++;
                $display("FAIL zeroize_abort_rk[%0d]: got %h, expected 0", s, o_Round_Key);
            end
        end
        seen_done = 1'b0;
        for (int k = 0; k < 14; k++) begin
            tick();
            if (o_Done === 1'b1) seen_done = 1'b1;
        end
        vectors++;
        if (seen_done !== 1'b0) begin
            miscompares++;
            $display("FAIL zeroize_no_done: got %b, expected 0", seen_done);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fips();
        test_back_to_back();
        test_ignore_start();
        test_random();
        test_out_of_range();
        test_async_reset();
`ifdef AES_KEY_ZEROIZE_EN
        test_zeroize();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/aes_key_expansion.md
Name: aes_key_expansion

Overview:
- Iterative AES-128 key schedule. Sits directly upstream of the encryption core and supplies its round keys.
- Takes one 128-bit cipher key and produces the 11 round keys (round 0..10), one round per clock.
- Holds all round keys in an internal register file; the core reads them by round index.
- The S-box substitution for SubWord is implemented in-block as a 256-entry combinational lookup function, four instances (one per byte of the rotated word).

Parameters:
- NR, 10, number of rounds; fixed at 10 for AES-128. Other values are unsupported and must raise an elaboration error.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- i_Start  input  1  single-cycle request to expand i_Key; honoured only in IDLE
- i_Key  input  128  cipher key, sampled on the edge where i_Start is accepted; byte 0 = bits [127:120]
- i_Round_Sel  input  4  round-key read index, 0..10
- o_Round_Key  output  128  round key selected by i_Round_Sel (combinational read)
- o_Busy  output  1  high while expansion is in progress
- o_Done  output  1  one-cycle pulse when round key 10 is written
- o_Keys_Valid  output  1  high once a full schedule is stored; stays high until the next accepted start

Behaviour:
- Reset (async, any state): FSM to IDLE, all 11 round-key registers to 0, rcon to 8'h01, round counter to 0. o_Busy=0, o_Done=0, o_Keys_Valid=0. o_Round_Key therefore reads 0 for every index.
- FSM states: IDLE, EXPAND.
- IDLE:
  - i_Start=1 at edge N: rk[0]<=i_Key, counter<=1, rcon<=8'h01, o_Keys_Valid<=0, o_Busy<=1, go to EXPAND.
  - i_Start=0: hold all state.
- EXPAND, one round per edge:
  - temp = SubWord(RotWord(w3)) XOR {rcon,24'h0}, where w0..w3 are the words of rk[counter-1] and w3 is the last word.
  - w0' = w0 ^ temp; w1' = w1 ^ w0'; w2' = w2 ^ w1'; w3' = w3 ^ w2'.
  - rk[counter] <= {w0',w1',w2',w3'}.
  - rcon <= xtime(rcon): shift left 1; XOR 8'h1b if the MSB was set. 0x80 is followed by 0x1b, then 0x36.
  - counter increments by 1.
- Completion (counter==10): at edge N+10, rk[10] is written and the FSM goes to IDLE. In the same edge o_Busy<=0, o_Done<=1 for exactly one cycle, and o_Keys_Valid<=1.
- Latency: start accepted at edge N; the full schedule is readable in the cycle after edge N+10 (10 cycles).
- i_Start while in EXPAND: ignored; no restart, no error.
- i_Start in the same cycle as o_Done=1: FSM is IDLE, so it is accepted. A new expansion starts and o_Keys_Valid drops at that edge.
- Read port:
  - i_Round_Sel 0..10 returns rk[sel].
  - i_Round_Sel 11..15 returns 128'h0.
  - Reads during EXPAND return partially updated contents; consumers gate on o_Keys_Valid.
- i_Key is not registered beyond rk[0]. It may change freely after the accepting edge.
- Reset asserted mid-expansion: immediate abort, all storage cleared, no o_Done.

Optional Feature:
- Macro: AES_KEY_ZEROIZE_EN.
- With the macro defined: an extra port i_Zeroize (input, 1). i_Zeroize=1 at any edge clears all rk[] to 0, forces IDLE, and drives o_Busy, o_Done and o_Keys_Valid to 0. It has priority over i_Start in the same cycle.
- Without the macro: the port does not exist and key material is cleared only by rst.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, pulse i_Start -> o_Done exactly 10 cycles later, then:
  - rk[1]=a0fafe1788542cb123a339392a6c7605
  - rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6
  - rk[0]=the input key
- All-zero key -> rk[1]=62636363626363636263636362636363, rk[10]=b4ef5bcb3e92e21123e951cf6f8f188e.
- Second i_Start pulsed at cycle 4 of an expansion -> ignored; o_Done still at cycle 10 with the first key's schedule.
- rst asserted at cycle 5 of an expansion, asynchronously between edges:
  - o_Busy drops immediately.
  - All indices read 0, o_Keys_Valid=0, and no o_Done follows.
- i_Round_Sel=11 and 15 after a valid schedule -> o_Round_Key=0. i_Start in the o_Done cycle with the zero key -> o_Keys_Valid falls next edge and the new schedule completes 10 cycles later.
- Zeroize, only with AES_KEY_ZEROIZE_EN:
  - i_Zeroize with i_Start in the same cycle after a valid schedule -> no start; all reads 0; o_Keys_Valid=0.
  - i_Zeroize at cycle 3 of an expansion -> abort with all reads 0 and no o_Done.
